// File: rtl/cache_fill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_arbiter_pkg
//  Description : Shared types and constants for the cache line fill arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_fill_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } fill_state_e;

    typedef enum logic [1:0] {
        INSTR = 2'd0,
        DATA1 = 2'd1,
        DATA2 = 2'd2
    } requester_id_t;

    localparam int          BEATS            = 8;
    localparam int          LINE_BITS        = BEATS * 64;
    localparam int          LINE_OFFSET_BITS = 6;
    localparam logic [12:0] READ_TAG         = 13'h1100;

endpackage
`default_nettype wire

// File: rtl/cache_fill_arbiter_rr_arbiter3.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter3
//  Description : Combinational three-way round-robin pick, searching from the
//                requester after last_grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter3
    import cache_fill_arbiter_pkg::*;
(
    input  logic [2:0]    req_valid,
    input  requester_id_t last_grant,
    output logic [2:0]    grant,
    output requester_id_t grant_id
);

    int w_cand;

    // Scan farthest candidate first so the nearest pending one wins.
    always_comb begin
        grant    = 3'b000;
        grant_id = INSTR;
        w_cand   = 0;
        for (int i = 3; i >= 1; i--) begin
            w_cand = (int'(last_grant) + i) % 3;
            if (req_valid[w_cand]) begin
                grant    = 3'b001 << w_cand;
                grant_id = requester_id_t'(w_cand[1:0]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_arbiter
//  Description : Round-robin owner of the memory bus for instruction/data cache
//                misses; fetches one line per grant and returns it with a pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_arbiter #(
    parameter int                       ADDR_WIDTH     = 64,
    parameter int                       BUS_DATA_WIDTH = 64,
    parameter int                       BUS_TAG_WIDTH  = 13,
    parameter int                       BEATS          = cache_fill_arbiter_pkg::BEATS,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = BUS_TAG_WIDTH'(cache_fill_arbiter_pkg::READ_TAG)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2:0]                      req_valid,
    input  logic [ADDR_WIDTH-1:0]           req_addr0,
    input  logic [ADDR_WIDTH-1:0]           req_addr1,
    input  logic [ADDR_WIDTH-1:0]           req_addr2,
    output logic [2:0]                      fill_valid,
    output logic [ADDR_WIDTH-1:0]           fill_addr,
    output logic [BEATS*BUS_DATA_WIDTH-1:0] fill_line,
    output logic                            busy,
    output logic                            bus_reqcyc,
    input  logic                            bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]       bus_req,
    output logic [BUS_TAG_WIDTH-1:0]        bus_reqtag,
    input  logic                            bus_respcyc,
    output logic                            bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0]       bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]        bus_resptag
);
    import cache_fill_arbiter_pkg::*;

    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_REQ  = REQ;
    localparam logic [1:0] c_ST_RESP = RESP;
    localparam logic [1:0] c_ST_DONE = DONE;

    localparam int c_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK =
        ~(ADDR_WIDTH'((64'd1 << LINE_OFFSET_BITS) - 64'd1));

    logic [1:0]                      r_state;
    requester_id_t                   r_owner;
    logic [2:0]                      r_owner_oh;
    requester_id_t                   r_last_grant;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [c_CNT_W-1:0]              r_count;
    logic [2:0]                      r_fill_valid;
    logic [ADDR_WIDTH-1:0]           r_fill_addr;
    logic [BEATS*BUS_DATA_WIDTH-1:0] r_fill_line;
    logic                            r_bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0]       r_bus_req;
    logic [BUS_TAG_WIDTH-1:0]        r_bus_reqtag;
    logic                            r_bus_respack;

    logic [2:0]            w_grant;
    requester_id_t         w_grant_id;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [ADDR_WIDTH-1:0] w_aligned;
    logic                  w_beat_ok;
    logic                  w_last_beat;

    rr_arbiter3 u_rr_arbiter3 (
        .req_valid  (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    always_comb begin
        w_sel_addr = req_addr0;
        case (w_grant_id)
            DATA1:   w_sel_addr = req_addr1;
            DATA2:   w_sel_addr = req_addr2;
            default: w_sel_addr = req_addr0;
        endcase
    end

    assign w_aligned   = w_sel_addr & c_LINE_MASK;
    assign w_beat_ok   = bus_respcyc && (bus_resptag == READ_TAG);
    assign w_last_beat = (r_count == c_CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_owner       <= INSTR;
            r_owner_oh    <= 3'b000;
            r_last_grant  <= DATA2;
            r_addr        <= '0;
            r_count       <= '0;
            r_fill_valid  <= 3'b000;
            r_fill_addr   <= '0;
            r_fill_line   <= '0;
            r_bus_reqcyc  <= 1'b0;
            r_bus_req     <= '0;
            r_bus_reqtag  <= '0;
            r_bus_respack <= 1'b0;
        end else begin
            r_fill_valid  <= 3'b000;
            r_bus_respack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (|req_valid) begin
                        r_owner      <= w_grant_id;
                        r_owner_oh   <= w_grant;
                        r_addr       <= w_aligned;
                        r_bus_reqcyc <= 1'b1;
                        r_bus_req    <= BUS_DATA_WIDTH'(w_aligned);
                        r_bus_reqtag <= READ_TAG;
                        r_state      <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (bus_reqack) begin
                        r_bus_reqcyc <= 1'b0;
                        r_bus_req    <= '0;
                        r_bus_reqtag <= '0;
                        r_state      <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    // The fill_line register doubles as the line buffer.
                    if (w_beat_ok) begin
                        r_fill_line[r_count*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
                        r_bus_respack <= 1'b1;
                        r_count       <= r_count + 1'b1;
                        if (w_last_beat) begin
                            r_fill_valid <= r_owner_oh;
                            r_fill_addr  <= r_addr;
                            r_state      <= c_ST_DONE;
                        end
                    end
                end
                default: begin
                    r_last_grant <= r_owner;
                    r_count      <= '0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign fill_valid  = r_fill_valid;
    assign fill_addr   = r_fill_addr;
    assign fill_line   = r_fill_line;
    assign busy        = (r_state != c_ST_IDLE);
    assign bus_reqcyc  = r_bus_reqcyc;
    assign bus_req     = r_bus_req;
    assign bus_reqtag  = r_bus_reqtag;
    assign bus_respack = r_bus_respack;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_arbiter
//  Description : Randomized self-checking bench for cache_fill_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_arbiter;

    localparam int          AW    = 64;
    localparam int          DW    = 64;
    localparam int          TW    = 13;
    localparam int          BEATS = 8;
    localparam logic [TW-1:0] TAG = 13'h1100;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        req_valid;
    logic [AW-1:0]     req_addr0, req_addr1, req_addr2;
    logic [2:0]        fill_valid;
    logic [AW-1:0]     fill_addr;
    logic [BEATS*DW-1:0] fill_line;
    logic              busy;
    logic              bus_reqcyc;
    logic              bus_reqack;
    logic [DW-1:0]     bus_req;
    logic [TW-1:0]     bus_reqtag;
    logic              bus_respcyc;
    logic              bus_respack;
    logic [DW-1:0]     bus_resp;
    logic [TW-1:0]     bus_resptag;

    int errors = 0;
    int checks = 0;
    int model_last = 2;
    logic [BEATS*DW-1:0] last_line;

    cache_fill_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .req_addr2   (req_addr2),
        .fill_valid  (fill_valid),
        .fill_addr   (fill_addr),
        .fill_line   (fill_line),
        .busy        (busy),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Round-robin reference: first pending requester after the last one served.
    function automatic int rr_pick(input int last, input logic [2:0] v);
        for (int i = 1; i <= 3; i++) begin
            if (v[(last + i) % 3]) return (last + i) % 3;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int id);
        if (id == 1) return req_addr1;
        if (id == 2) return req_addr2;
        return req_addr0;
    endfunction

    function automatic logic [DW-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic run_fill(input int ack_delay, input int gap, input int bad_at,
                            input bit keep, input bit counting);
        int owner;
        int k;
        int sent;
        bit good;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] data;
        logic [BEATS*DW-1:0] exp_line;
        owner = rr_pick(model_last, req_valid);
        exp_addr = addr_of(owner) & ~64'h3f;
        exp_line = '0;
        @(negedge clk);
        checks++;
        if ({busy, bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 1'b1, exp_addr, TAG}) begin
            errors++;
            $display("FAIL req_issue: busy=%b cyc=%b req=%h tag=%h, want busy=1 cyc=1 req=%h tag=%h",
                     busy, bus_reqcyc, bus_req, bus_reqtag, exp_addr, TAG);
        end
        for (int d = 0; d < ack_delay; d++) begin
            bus_respcyc = 1'b1;
            bus_resptag = TAG;
            bus_resp    = rand64();
            @(negedge clk);
            checks++;
            if ({bus_respack, bus_reqcyc, bus_req, bus_reqtag} !== {1'b0, 1'b1, exp_addr, TAG}) begin
                errors++;
                $display("FAIL req_hold[%0d]: ack=%b cyc=%b req=%h tag=%h, want ack=0 cyc=1 req=%h tag=%h",
                         d, bus_respack, bus_reqcyc, bus_req, bus_reqtag, exp_addr, TAG);
            end
        end
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b1;
        @(negedge clk);
        bus_reqack  = 1'b0;
        checks++;
        if ({bus_reqcyc, bus_req, bus_reqtag} !== '0) begin
            errors++;
            $display("FAIL req_release: cyc=%b req=%h tag=%h, want all zero",
                     bus_reqcyc, bus_req, bus_reqtag);
        end
        k = 0;
        sent = 0;
        while (k < BEATS) begin
            good = (sent != bad_at);
            data = (counting && good) ? DW'(k) : rand64();
            bus_respcyc = 1'b1;
            bus_resptag = good ? TAG : 13'h0000;
            bus_resp    = data;
            if (good) exp_line[k*DW +: DW] = data;
            @(negedge clk);
            bus_respcyc = 1'b0;
            bus_resptag = TW'($urandom);
            sent++;
            if (good) k++;
            checks++;
            if ({bus_reqcyc, bus_respack} !== {1'b0, good}) begin
                errors++;
                $display("FAIL beat_ack[%0d]: reqcyc=%b respack=%b, want reqcyc=0 respack=%b",
                         sent - 1, bus_reqcyc, bus_respack, good);
            end
            if (k == BEATS && good) begin
                checks++;
                if ({busy, fill_valid, fill_addr} !== {1'b1, 3'b001 << owner, exp_addr}) begin
                    errors++;
                    $display("FAIL fill_pulse: busy=%b valid=%b addr=%h, want busy=1 valid=%b addr=%h",
                             busy, fill_valid, fill_addr, 3'b001 << owner, exp_addr);
                end
                checks++;
                if (fill_line !== exp_line) begin
                    errors++;
                    $display("FAIL fill_line: got %h want %h", fill_line, exp_line);
                end
                if (!keep) req_valid[owner] = 1'b0;
            end else begin
                checks++;
                if (fill_valid !== 3'b000) begin
                    errors++;
                    $display("FAIL early_fill: valid=%b want 000 after %0d beats", fill_valid, k);
                end
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    checks++;
                    if ({bus_respack, fill_valid} !== 4'b0000) begin
                        errors++;
                        $display("FAIL gap_idle: respack=%b valid=%b, want 0 and 000",
                                 bus_respack, fill_valid);
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, fill_valid, bus_respack, fill_addr, fill_line} !== {5'b0, exp_addr, exp_line}) begin
            errors++;
            $display("FAIL post_fill: busy=%b valid=%b respack=%b addr=%h, want 0/000/0 addr=%h with line held",
                     busy, fill_valid, bus_respack, fill_addr, exp_addr);
        end
        model_last = owner;
        last_line  = exp_line;
    endtask

    task automatic quiet_bus();
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
    endtask

    task automatic randomize_addrs();
        req_addr0 = rand64();
        req_addr1 = rand64();
        req_addr2 = rand64();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_valid   = 3'($urandom);
            bus_reqack  = 1'($urandom);
            bus_respcyc = 1'($urandom);
            bus_resp    = rand64();
            bus_resptag = ($urandom % 2 == 0) ? TAG : TW'($urandom);
            randomize_addrs();
            @(negedge clk);
            checks++;
            if ({fill_valid, fill_addr, fill_line, busy, bus_reqcyc, bus_req, bus_reqtag, bus_respack} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: valid=%b addr=%h busy=%b cyc=%b req=%h tag=%h ack=%b, want all 0",
                         c, fill_valid, fill_addr, busy, bus_reqcyc, bus_req, bus_reqtag, bus_respack);
            end
        end
        reset = 1'b0;
        quiet_bus();
        model_last = 2;
        req_valid = 3'b111;
        randomize_addrs();
        run_fill(1, 0, -1, 0, 0);
        req_valid = 3'b000;
    endtask

    task automatic test_instr_fill();
        req_valid = 3'b001;
        req_addr0 = 64'h1234;
        run_fill(2, 0, -1, 0, 1);
        req_valid = 3'b000;
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_last = 2;
        randomize_addrs();
        req_valid = 3'b111;
        for (int r = 0; r < 4; r++) begin
            run_fill(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), -1, 1, 0);
            checks++;
            if (model_last != ((r % 3))) begin
                errors++;
                $display("FAIL rr_order[%0d]: owner %0d want %0d", r, model_last, r % 3);
            end
        end
        req_valid = 3'b000;
    endtask

    task automatic test_ack_stall();
        randomize_addrs();
        req_valid = 3'b100;
        run_fill(10, 0, -1, 0, 0);
        req_valid = 3'b000;
    endtask

    task automatic test_gaps_bad_tag();
        randomize_addrs();
        req_valid = 3'($urandom_range(1, 7));
        run_fill(1, 2, 3, 0, 0);
        req_valid = 3'b000;
    endtask

    task automatic test_reset_mid_fill();
        randomize_addrs();
        req_valid = 3'b010;
        @(negedge clk);
        req_valid  = 3'b000;
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus_respcyc = 1'b1;
            bus_resptag = TAG;
            bus_resp    = rand64();
            @(negedge clk);
        end
        reset       = 1'b1;
        bus_resp    = rand64();
        @(negedge clk);
        reset = 1'b0;
        quiet_bus();
        checks++;
        if ({fill_valid, fill_addr, fill_line, busy, bus_reqcyc, bus_req, bus_reqtag, bus_respack} !== '0) begin
            errors++;
            $display("FAIL reset_mid_fill: valid=%b addr=%h busy=%b cyc=%b req=%h ack=%b, want all 0",
                     fill_valid, fill_addr, busy, bus_reqcyc, bus_req, bus_respack);
        end
        model_last = 2;
        randomize_addrs();
        req_valid = 3'($urandom_range(1, 7));
        run_fill(1, 0, -1, 0, 0);
        req_valid = 3'b000;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 3'b000;
        req_addr0 = '0;
        req_addr1 = '0;
        req_addr2 = '0;
        last_line = '0;
        quiet_bus();
        test_reset();
        test_instr_fill();
        test_round_robin();
        test_ack_stall();
        test_gaps_bad_tag();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
